// File: rtl/sipo_deserializer.sv
// Serial-in/parallel-out deserializer: assembles one bit per cycle from a
// valid/ready serial port into a WIDTH-bit word held in a one-entry output
// register. Bit order is latched per frame; overflow is a sticky drop flag.
// Optional build macro PARITY_CHECK_EN appends an even-parity bit to each
// frame and adds the out_perr output.
module sipo_deserializer #(
  parameter int unsigned WIDTH = 4,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             ser_in,
  input  logic             ser_valid,
  output logic             ser_ready,
  input  logic             lsb_first,
  input  logic             frame_clr,
  output logic [WIDTH-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
`ifdef PARITY_CHECK_EN
  output logic             out_perr,
`endif
  output logic             overflow
);

`ifdef PARITY_CHECK_EN
  localparam int unsigned FRAME = WIDTH + 1;
`else
  localparam int unsigned FRAME = WIDTH;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(FRAME - 1);

  logic [WIDTH-1:0] r_shreg;
  logic [CNT_W-1:0] r_cnt;
  logic             r_lsb;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_valid;
  logic             r_overflow;
`ifdef PARITY_CHECK_EN
  logic             r_out_perr;
`endif

  logic             w_ready;
  logic             w_accept;
  logic             w_drop;
  logic             w_order;
  logic             w_done;
  logic [WIDTH-1:0] w_shift;

  // Only the frame-completing bit stalls, and only while a word is still pending.
  assign w_ready  = !(r_out_valid && !out_ready && (r_cnt == LAST));
  assign w_accept = ser_valid && w_ready && !frame_clr;
  assign w_drop   = ser_valid && !w_ready && !frame_clr;
  assign w_done   = w_accept && (r_cnt == LAST);
  // The first bit of a frame takes the live lsb_first; later bits use the latch.
  assign w_order  = (r_cnt == '0) ? lsb_first : r_lsb;
  assign w_shift  = w_order ? {ser_in, r_shreg[WIDTH-1:1]}
                            : {r_shreg[WIDTH-2:0], ser_in};

  assign ser_ready = w_ready;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign overflow  = r_overflow;
`ifdef PARITY_CHECK_EN
  assign out_perr  = r_out_perr;
`endif

  // Bit assembly: counter, shift register and per-frame order latch.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_shreg <= '0;
      r_cnt   <= '0;
      r_lsb   <= 1'b0;
    end else if (frame_clr) begin
      r_shreg <= '0;
      r_cnt   <= '0;
    end else if (w_accept) begin
      if (r_cnt == '0) r_lsb <= lsb_first;
`ifdef PARITY_CHECK_EN
      // The parity bit is checked but never enters the data register.
      if (r_cnt != LAST) r_shreg <= w_shift;
`else
      r_shreg <= w_shift;
`endif
      r_cnt <= w_done ? '0 : r_cnt + CNT_W'(1);
    end
  end

  // Output word register; a completing word overrides a same-cycle consume.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
`ifdef PARITY_CHECK_EN
      r_out_perr  <= 1'b0;
`endif
    end else if (w_done) begin
`ifdef PARITY_CHECK_EN
      r_out_data  <= r_shreg;
      r_out_perr  <= ^{r_shreg, ser_in};
`else
      r_out_data  <= w_shift;
`endif
      r_out_valid <= 1'b1;
    end else if (r_out_valid && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  // Sticky record of a bit offered while stalled.
  always_ff @(posedge clock) begin
    if (reset)       r_overflow <= 1'b0;
    else if (w_drop) r_overflow <= 1'b1;
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// Directed bench for sipo_deserializer (default build, WIDTH=4).
module tb_sipo_deserializer;

  localparam int unsigned WIDTH = 4;
  localparam int unsigned NVEC  = 47;

  logic             clock = 1'b0;
  logic             reset;
  logic             ser_in;
  logic             ser_valid;
  logic             ser_ready;
  logic             lsb_first;
  logic             frame_clr;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             overflow;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       sv;
    logic       si;
    logic       lsb;
    logic       clr;
    logic       ordy;
    logic       e_rdy;
    logic       e_vld;
    logic [3:0] e_data;
    logic       e_ovf;
  } vec_t;

  vec_t vecs [NVEC];

  sipo_deserializer #(.WIDTH(WIDTH), .CNT_W(3)) dut (
    .clock     (clock),
    .reset     (reset),
    .ser_in    (ser_in),
    .ser_valid (ser_valid),
    .ser_ready (ser_ready),
    .lsb_first (lsb_first),
    .frame_clr (frame_clr),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b", name, act, exp);
    end
  endtask

  task automatic set_row(input int i, input logic rst, input logic sv, input logic si,
                         input logic lsb, input logic clr, input logic ordy,
                         input logic e_rdy, input logic e_vld, input logic [3:0] e_data,
                         input logic e_ovf);
    vecs[i] = '{rst, sv, si, lsb, clr, ordy, e_rdy, e_vld, e_data, e_ovf};
  endtask

  task automatic drive(input logic rst, input logic sv, input logic si, input logic lsb,
                       input logic clr, input logic ordy);
    reset = rst; ser_valid = sv; ser_in = si; lsb_first = lsb; frame_clr = clr; out_ready = ordy;
  endtask

  initial begin
    int waited;
    // rst sv si lsb clr ordy | rdy vld data ovf
    // MSB-first 1,0,1,1
    set_row( 0, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row( 1, 0,1,0,0,0,1, 1,0,4'b0000,0);
    set_row( 2, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row( 3, 0,1,1,0,0,1, 1,1,4'b1011,0);
    set_row( 4, 0,0,0,0,0,1, 1,0,4'b1011,0);
    // LSB-first 1,0,1,1 with lsb_first wiggled mid-frame
    set_row( 5, 0,1,1,1,0,1, 1,0,4'b1011,0);
    set_row( 6, 0,1,0,0,0,1, 1,0,4'b1011,0);
    set_row( 7, 0,1,1,0,0,1, 1,0,4'b1011,0);
    set_row( 8, 0,1,1,1,0,1, 1,1,4'b1101,0);
    set_row( 9, 0,0,0,0,0,1, 1,0,4'b1101,0);
    // 8 contiguous bits 1,1,0,0,0,1,0,1
    set_row(10, 0,1,1,0,0,1, 1,0,4'b1101,0);
    set_row(11, 0,1,1,0,0,1, 1,0,4'b1101,0);
    set_row(12, 0,1,0,0,0,1, 1,0,4'b1101,0);
    set_row(13, 0,1,0,0,0,1, 1,1,4'b1100,0);
    set_row(14, 0,1,0,0,0,1, 1,0,4'b1100,0);
    set_row(15, 0,1,1,0,0,1, 1,0,4'b1100,0);
    set_row(16, 0,1,0,0,0,1, 1,0,4'b1100,0);
    set_row(17, 0,1,1,0,0,1, 1,1,4'b0101,0);
    set_row(18, 0,0,0,0,0,1, 1,0,4'b0101,0);
    // word 1010 with out_ready low, then 1,1,1 and a stalled 4th bit 0
    set_row(19, 0,1,1,0,0,0, 1,0,4'b0101,0);
    set_row(20, 0,1,0,0,0,0, 1,0,4'b0101,0);
    set_row(21, 0,1,1,0,0,0, 1,0,4'b0101,0);
    set_row(22, 0,1,0,0,0,0, 1,1,4'b1010,0);
    set_row(23, 0,1,1,0,0,0, 1,1,4'b1010,0);
    set_row(24, 0,1,1,0,0,0, 1,1,4'b1010,0);
    set_row(25, 0,1,1,0,0,0, 1,1,4'b1010,0);
    set_row(26, 0,1,0,0,0,0, 0,1,4'b1010,1);
    set_row(27, 0,1,0,0,0,0, 0,1,4'b1010,1);
    set_row(28, 0,1,0,0,0,1, 1,1,4'b1110,1);
    set_row(29, 0,0,0,0,0,1, 1,0,4'b1110,1);
    // reset, 2 bits, frame_clr with ser_valid, then 0,1,1,0
    set_row(30, 1,0,0,0,0,1, 1,0,4'b0000,0);
    set_row(31, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row(32, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row(33, 0,1,1,0,1,1, 1,0,4'b0000,0);
    set_row(34, 0,1,0,0,0,1, 1,0,4'b0000,0);
    set_row(35, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row(36, 0,1,1,0,0,1, 1,0,4'b0000,0);
    set_row(37, 0,1,0,0,0,1, 1,1,4'b0110,0);
    // two bits then reset mid-frame
    set_row(38, 0,1,1,0,0,1, 1,0,4'b0110,0);
    set_row(39, 0,1,0,0,0,1, 1,0,4'b0110,0);
    set_row(40, 1,0,0,0,0,1, 1,0,4'b0000,0);
    set_row(41, 0,0,0,0,0,1, 1,0,4'b0000,0);
    // fresh frame after reset must take exactly 4 bits
    set_row(42, 0,1,0,0,0,1, 1,0,4'b0000,0);
    set_row(43, 0,1,0,0,0,1, 1,0,4'b0000,0);
    set_row(44, 0,1,0,0,0,1, 1,0,4'b0000,0);
    set_row(45, 0,1,1,0,0,1, 1,1,4'b0001,0);
    set_row(46, 0,0,0,0,0,0, 1,1,4'b0001,0);

    // Reset state
    drive(1, 0, 0, 0, 0, 1);
    repeat (2) @(posedge clock);
    #1;
    check("reset_out_data", out_data, 4'b0000);
    check("reset_out_valid", {3'b0, out_valid}, 4'b0000);
    check("reset_overflow", {3'b0, overflow}, 4'b0000);
    check("reset_ser_ready", {3'b0, ser_ready}, 4'b0001);

    // Table: drive on negedge, check ser_ready before the edge, registers after
    for (int i = 0; i < int'(NVEC); i++) begin
      @(negedge clock);
      drive(vecs[i].rst, vecs[i].sv, vecs[i].si, vecs[i].lsb, vecs[i].clr, vecs[i].ordy);
      #1;
      check($sformatf("v%0d_ser_ready", i), {3'b0, ser_ready}, {3'b0, vecs[i].e_rdy});
      @(posedge clock);
      #1;
      check($sformatf("v%0d_out_valid", i), {3'b0, out_valid}, {3'b0, vecs[i].e_vld});
      check($sformatf("v%0d_out_data", i), out_data, vecs[i].e_data);
      check($sformatf("v%0d_overflow", i), {3'b0, overflow}, {3'b0, vecs[i].e_ovf});
    end

    // Pending word held stable while out_ready stays low
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(0, 0, 0, 0, 0, 0);
      @(posedge clock);
      #1;
      check($sformatf("hold%0d_valid", k), {3'b0, out_valid}, 4'b0001);
      check($sformatf("hold%0d_data", k), out_data, 4'b0001);
    end

    // frame_clr while a word is pending leaves the output register alone
    @(negedge clock);
    drive(0, 1, 1, 0, 1, 0);
    @(posedge clock);
    #1;
    check("clr_keeps_valid", {3'b0, out_valid}, 4'b0001);
    check("clr_keeps_data", out_data, 4'b0001);
    check("clr_no_overflow", {3'b0, overflow}, 4'b0000);

    // Consume it
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 1);
    @(posedge clock);
    #1;
    check("consume_valid", {3'b0, out_valid}, 4'b0000);

    // LSB-first 1,1,1,0 with a bounded wait for the word
    for (int k = 0; k < 4; k++) begin
      @(negedge clock);
      drive(0, 1, (k != 3), 1, 0, 0);
    end
    @(negedge clock);
    drive(0, 0, 0, 0, 0, 0);
    waited = 0;
    while (!out_valid && waited < 10) begin
      @(negedge clock);
      waited++;
    end
    check("wait_word_timeout", {3'b0, out_valid}, 4'b0001);
    check("wait_word_data", out_data, 4'b0111);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
